// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, the halt opcode and the
// fetch-unit FSM state type.
package cpu_pkg;

  typedef enum logic [1:0] {
    PcSrcInc    = 2'b00,
    PcSrcBranch = 2'b01,
    PcSrcReg    = 2'b10,
    PcSrcJump   = 2'b11
  } pc_src_e;

  localparam logic [5:0] OpHalt = 6'b111111;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StFetch  = 2'b01,
    StValid  = 2'b10,
    StHalted = 2'b11
  } ifu_state_e;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:26] == OpHalt;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, branch, register (jr) or jump.
module pc_next
  import cpu_pkg::*;
(
  input  pc_src_e     pc_src_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] ext_imm_i,
  input  logic [31:0] rs_data_i,
  input  logic [25:0] jump_target_i,
  output logic [31:0] next_pc_o
);

  // Select the next PC; all additions wrap modulo 2^32.
  always_comb begin
    next_pc_o = pc4_i;
    unique case (pc_src_i)
      PcSrcInc:    next_pc_o = pc4_i;
      PcSrcBranch: next_pc_o = pc4_i + {ext_imm_i[29:0], 2'b00};
      PcSrcReg:    next_pc_o = rs_data_i;
      PcSrcJump:   next_pc_o = {pc4_i[31:28], jump_target_i, 2'b00};
      default:     next_pc_o = pc4_i;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, instruction register and a four-state
// request/fetch/present/halt FSM. Next-PC selection lives in pc_next.
// Optional: define IFU_MISALIGN_TRAP_EN to halt on a fetch from a misaligned PC
// and expose the sticky misalign flag.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic        instr_ack,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  input  logic [31:0] RsData,
  input  logic [31:0] IMData,
  output logic [31:0] IAddr,
  output logic        InsMemRW,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] Instr,
  output logic        instr_valid,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        pc_wr_allowed;
  logic        fetch_trap;

  assign pc4 = pc_q + 32'd4;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign fetch_trap = (pc_q[1:0] != 2'b00);
`else
  assign fetch_trap = 1'b0;
`endif

  pc_next u_pc_next (
    .pc_src_i      (pc_src_e'(PCSrc)),
    .pc4_i         (pc4),
    .ext_imm_i     (ExtImm),
    .rs_data_i     (RsData),
    .jump_target_i (instr_q[25:0]),
    .next_pc_o     (next_pc)
  );

  // State, PC and IR registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fetch_req) state_d = fetch_trap ? StHalted : StFetch;
      StFetch:  state_d = StValid;
      StValid:  if (instr_ack) state_d = is_halt(instr_q) ? StHalted : StIdle;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // PC/IR update: PC writable only between fetches, IR captured at end of FETCH.
  always_comb begin
    pc_wr_allowed = (state_q == StIdle) || (state_q == StValid);
    pc_d          = (PCWre && pc_wr_allowed) ? next_pc : pc_q;
    instr_d       = (state_q == StFetch) ? IMData : instr_q;
`ifdef IFU_MISALIGN_TRAP_EN
    misalign_d    = misalign_q | ((state_q == StIdle) && fetch_req && fetch_trap);
`endif
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    IAddr       = pc_q;
    PC          = pc_q;
    PC4         = pc4;
    Instr       = instr_q;
    InsMemRW    = (state_q != StFetch);
    instr_valid = (state_q == StValid);
    halted      = (state_q == StHalted);
`ifdef IFU_MISALIGN_TRAP_EN
    misalign    = misalign_q;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        instr_ack = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ExtImm = 32'h0;
  logic [31:0] RsData = 32'h0;
  logic [31:0] IMData = 32'h0;
  logic [31:0] IAddr;
  logic        InsMemRW;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        halted;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .fetch_req   (fetch_req),
    .instr_ack   (instr_ack),
    .PCWre       (PCWre),
    .PCSrc       (PCSrc),
    .ExtImm      (ExtImm),
    .RsData      (RsData),
    .IMData      (IMData),
    .IAddr       (IAddr),
    .InsMemRW    (InsMemRW),
    .PC          (PC),
    .PC4         (PC4),
    .Instr       (Instr),
    .instr_valid (instr_valid),
`ifdef IFU_MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; fetch_req = 1'b0; instr_ack = 1'b0; PCWre = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  // Load PC through the jr path (legal in IDLE or VALID).
  task automatic load_pc(input logic [31:0] v);
    PCSrc = 2'b10; RsData = v; PCWre = 1'b1;
    step();
    PCWre = 1'b0;
  endtask

  // Request a fetch and stop once the word is presented (VALID).
  task automatic do_fetch(input logic [31:0] data);
    IMData = data; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
  endtask

  task automatic do_ack();
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    n_checks++; if (Instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", Instr, 32'h0); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (InsMemRW !== 1'b1) begin n_fail++; $display("FAIL reset_memrw: got %b want 1", InsMemRW); end
    n_checks++; if (PC4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h want %h", PC4, 32'h4); end
    // No request: stays idle.
    step();
    n_checks++; if (InsMemRW !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got rw=%b v=%b want rw=1 v=0", InsMemRW, instr_valid); end
  endtask

  task automatic test_fetch();
    IMData = 32'hE000_0019; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    n_checks++; if (IAddr !== 32'h0) begin n_fail++; $display("FAIL fetch_iaddr: got %h want %h", IAddr, 32'h0); end
    n_checks++; if (InsMemRW !== 1'b0) begin n_fail++; $display("FAIL fetch_memrw: got %b want 0", InsMemRW); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid: got %b want 0", instr_valid); end
    step();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid: got %b want 1", instr_valid); end
    n_checks++; if (Instr !== 32'hE000_0019) begin n_fail++; $display("FAIL fetch_instr: got %h want %h", Instr, 32'hE000_0019); end
    n_checks++; if (InsMemRW !== 1'b1) begin n_fail++; $display("FAIL valid_memrw: got %b want 1", InsMemRW); end
    // Held without ack; IR stable even if memory data moves.
    IMData = 32'h1111_1111;
    step();
    n_checks++; if (instr_valid !== 1'b1 || Instr !== 32'hE000_0019) begin n_fail++; $display("FAIL valid_hold: got v=%b %h want v=1 %h", instr_valid, Instr, 32'hE000_0019); end
    do_ack();
    n_checks++; if (instr_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL ack_idle: got v=%b h=%b want 0 0", instr_valid, halted); end
  endtask

  task automatic test_jump();
    load_pc(32'h80);
    n_checks++; if (PC !== 32'h80) begin n_fail++; $display("FAIL jr_load: got %h want %h", PC, 32'h80); end
    do_fetch(32'hE800_0026);
    n_checks++; if (PC4 !== 32'h84) begin n_fail++; $display("FAIL jump_pc4: got %h want %h", PC4, 32'h84); end
    // Jump and ack on the same edge.
    PCSrc = 2'b11; PCWre = 1'b1; instr_ack = 1'b1;
    step();
    PCWre = 1'b0; instr_ack = 1'b0;
    n_checks++; if (PC !== 32'h98) begin n_fail++; $display("FAIL jump_pc: got %h want %h", PC, 32'h98); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_ack: got %b want 0", instr_valid); end
  endtask

  task automatic test_branch();
    load_pc(32'h90);
    ExtImm = 32'hFFFF_FFFE; PCSrc = 2'b01; PCWre = 1'b1;
    step();
    PCWre = 1'b0;
    n_checks++; if (PC !== 32'h8C) begin n_fail++; $display("FAIL branch_pc: got %h want %h", PC, 32'h8C); end
    PCSrc = 2'b00; PCWre = 1'b1;
    step();
    PCWre = 1'b0;
    n_checks++; if (PC !== 32'h90) begin n_fail++; $display("FAIL inc_pc: got %h want %h", PC, 32'h90); end
  endtask

  task automatic test_pcwre_fetch();
    load_pc(32'h84);
    n_checks++; if (PC !== 32'h84) begin n_fail++; $display("FAIL jr_pc: got %h want %h", PC, 32'h84); end
    // PCWre with fetch_req in IDLE: FETCH uses the new PC.
    PCSrc = 2'b10; RsData = 32'h200; PCWre = 1'b1; fetch_req = 1'b1; IMData = 32'h0000_0001;
    step();
    fetch_req = 1'b0; RsData = 32'h300;
    n_checks++; if (IAddr !== 32'h200) begin n_fail++; $display("FAIL req_wre_iaddr: got %h want %h", IAddr, 32'h200); end
    // PCWre still high during FETCH must be ignored.
    step();
    PCWre = 1'b0;
    n_checks++; if (PC !== 32'h200) begin n_fail++; $display("FAIL fetch_wre_ignored: got %h want %h", PC, 32'h200); end
    do_ack();
    // Wrap-around of PC+4.
    load_pc(32'hFFFF_FFFC);
    n_checks++; if (PC4 !== 32'h0) begin n_fail++; $display("FAIL pc4_wrap: got %h want %h", PC4, 32'h0); end
    PCSrc = 2'b00; PCWre = 1'b1;
    step();
    PCWre = 1'b0;
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want %h", PC, 32'h0); end
  endtask

  task automatic test_halt();
    load_pc(32'h10);
    do_fetch(32'hFC00_0000);
    do_ack();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got %b want 1", halted); end
    fetch_req = 1'b1; PCWre = 1'b1; PCSrc = 2'b10; RsData = 32'h500;
    for (int i = 0; i < 3; i++) step();
    fetch_req = 1'b0; PCWre = 1'b0;
    n_checks++; if (PC !== 32'h10) begin n_fail++; $display("FAIL halt_pc: got %h want %h", PC, 32'h10); end
    n_checks++; if (halted !== 1'b1 || InsMemRW !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got h=%b rw=%b v=%b want 1 1 0", halted, InsMemRW, instr_valid); end
    do_reset();
    n_checks++; if (halted !== 1'b0 || PC !== 32'h0) begin n_fail++; $display("FAIL halt_reset: got h=%b pc=%h want 0 0", halted, PC); end
  endtask

  task automatic test_reset_mid_fetch();
    load_pc(32'h40);
    do_fetch(32'h1234_5678);
    do_ack();
    n_checks++; if (Instr !== 32'h1234_5678) begin n_fail++; $display("FAIL pre_reset_instr: got %h want %h", Instr, 32'h1234_5678); end
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    n_checks++; if (InsMemRW !== 1'b0) begin n_fail++; $display("FAIL mid_fetch_state: got %b want 0", InsMemRW); end
    Reset = 1'b1; PCWre = 1'b1; PCSrc = 2'b10; RsData = 32'h700; instr_ack = 1'b1;
    step();
    Reset = 1'b0; PCWre = 1'b0; instr_ack = 1'b0;
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL midfetch_pc: got %h want %h", PC, 32'h0); end
    n_checks++; if (Instr !== 32'h0) begin n_fail++; $display("FAIL midfetch_instr: got %h want %h", Instr, 32'h0); end
    n_checks++; if (instr_valid !== 1'b0 || InsMemRW !== 1'b1) begin n_fail++; $display("FAIL midfetch_state: got v=%b rw=%b want 0 1", instr_valid, InsMemRW); end
    step();
    n_checks++; if (instr_valid !== 1'b0 || InsMemRW !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL midfetch_idle: got v=%b rw=%b h=%b want 0 1 0", instr_valid, InsMemRW, halted); end
  endtask

`ifdef IFU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    do_reset();
    load_pc(32'h2);
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pre: got %b want 0", misalign); end
    IMData = 32'hAAAA_AAAA; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    n_checks++; if (halted !== 1'b1 || misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_trap: got h=%b m=%b want 1 1", halted, misalign); end
    step();
    n_checks++; if (Instr !== 32'h0) begin n_fail++; $display("FAIL misalign_nofetch: got %h want %h", Instr, 32'h0); end
    do_reset();
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_reset: got %b want 0", misalign); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_jump();
    test_branch();
    test_pcwre_fetch();
    test_halt();
    test_reset_mid_fetch();
`ifdef IFU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port fetch_req  input  1  control unit requests one instruction fetch.
REQ-005 SHALL have port instr_ack  input  1  control unit consumes the presented instruction.
REQ-006 SHALL have port PCWre  input  1  PC write enable.
REQ-007 SHALL have port PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 register (jr), 11 jump.
REQ-008 SHALL have port ExtImm  input  32  sign-extended branch immediate.
REQ-009 SHALL have port RsData  input  32  register value for jr.
REQ-010 SHALL have port IMData  input  32  instruction word from the instruction memory.
REQ-011 SHALL have port IAddr  output  32  byte address to the instruction memory.
REQ-012 SHALL have port InsMemRW  output  1  memory control; 0 = read.
REQ-013 SHALL have ports PC  output  32 (current PC) and PC4  output  32 (PC+4, jal return address).
REQ-014 SHALL have ports Instr  output  32 (instruction register), instr_valid  output  1, halted  output  1.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, VALID, HALTED.
REQ-016 IDLE: fetch_req=1 -> FETCH; otherwise stay in IDLE.
REQ-017 FETCH (exactly one cycle): IAddr=PC, InsMemRW=0, Instr<=IMData at the cycle's end, then -> VALID.
REQ-018 instr_valid SHALL be 1 only in VALID, i.e. two edges after fetch_req is sampled in IDLE.
REQ-019 VALID: Instr held stable; instr_ack=1 -> IDLE, or -> HALTED if Instr[31:26]==6'b111111.
REQ-020 HALTED: ignore fetch_req and PCWre, halted=1; leave only via Reset.
REQ-021 IAddr SHALL equal PC in every state; InsMemRW SHALL be 1 outside FETCH.
REQ-022 PC4 SHALL equal PC+32'd4, combinational, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-023 Next PC: 00 PC+4; 01 PC+4+(ExtImm<<2); 10 RsData; 11 {PC4[31:28], Instr[25:0], 2'b00}; all mod 2^32.
REQ-024 PCWre SHALL update PC only in IDLE or VALID; PCWre in FETCH or HALTED SHALL be ignored.
REQ-025 PCWre and fetch_req together in IDLE: PC updates and the following FETCH uses the new PC.
REQ-026 PCWre and instr_ack together in VALID: both take effect on the same edge.

Reset
REQ-027 Reset=1 at an edge SHALL set PC=RESET_PC, Instr=0, state=IDLE, instr_valid=0, halted=0, InsMemRW=1, from any state including mid-FETCH.
REQ-028 Reset SHALL take priority over fetch_req, instr_ack and PCWre.

Configuration
REQ-029 With IFU_MISALIGN_TRAP_EN defined: a fetch_req when PC[1:0]!=0 SHALL go to HALTED without fetching, and output misalign (1 bit, reset 0) SHALL set to 1.
REQ-030 Without IFU_MISALIGN_TRAP_EN: no misalign port; PC[1:0] SHALL NOT be checked.

Structure
REQ-031 Shared package cpu_pkg SHALL hold PCSrc encodings, HALT opcode 6'b111111 and the FSM state type.
REQ-032 Next-PC mux SHALL be sub-module pc_next (combinational); FSM, PC and IR registers stay in instr_fetch.

Verification
REQ-033 Reset, then fetch_req with IMData=0xE000_0019 -> IAddr=0, Instr=0xE000_0019 and instr_valid=1 two edges later.
REQ-034 PC=0x80, Instr=0xE800_0026, PCSrc=11, PCWre -> PC=0x98; PC4 was 0x84 beforehand.
REQ-035 PC=0x90, ExtImm=0xFFFF_FFFE, PCSrc=01, PCWre -> PC=0x8C.
REQ-036 PCSrc=10, RsData=0x84, PCWre -> PC=0x84; PCWre held during FETCH -> PC unchanged.
REQ-037 Fetch of 0xFC00_0000, then instr_ack -> halted=1; further fetch_req/PCWre ignored until Reset.
REQ-038 Reset asserted during FETCH -> next cycle state IDLE, PC=RESET_PC, Instr=0, instr_valid=0.
